// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter.
// The read tag carries the widest channel id (8 channels); narrower configs leave upper id bits zero.
package sram_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int TAG_ID_MAX_W = 3;

  typedef struct packed {
    logic                    valid;
    logic [TAG_ID_MAX_W-1:0] id;
  } rd_tag_t;

  function automatic int id_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational one-hot grant: round-robin starting after ptr, or fixed lowest-index priority.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  arb_mode_e         mode,
  output logic [NUM_CH-1:0] gnt
);

  int idx;

  // Loops run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt = '0;
    idx = 0;
    if (mode == ARB_FIXED) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = (int'(ptr) + k) % NUM_CH;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// N-channel arbiter sharing one single-port SRAM macro; reads are tagged so
// returned data is steered back to the issuing channel after RD_LAT cycles.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   web,
  input  logic [NUM_CH*ADDR_W-1:0]       addr,
  input  logic [NUM_CH*DATA_W-1:0]       wdata,
  output logic [NUM_CH-1:0]              gnt,
  output logic [NUM_CH-1:0]              rvalid,
  output logic [DATA_W-1:0]              rdata,
  output logic                           sram_cs,
  output logic                           sram_oe,
  output logic [DATA_W/8-1:0]            sram_web,
  output logic [ADDR_W-1:0]              sram_a,
  output logic [DATA_W-1:0]              sram_di,
  input  logic [DATA_W-1:0]              sram_do
);

  localparam int        BW   = DATA_W / 8;
  localparam int        ID_W = id_w(NUM_CH);
  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  logic [ID_W-1:0]   ptr;
  logic [NUM_CH-1:0] arb_gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [BW-1:0]     web_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              gnt_any;
  logic              rd_gnt;
  logic              tag_busy;
  rd_tag_t           tag_p [RD_LAT];

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .mode (MODE),
    .gnt  (arb_gnt)
  );

  // Reset masks the combinational grant so nothing reaches the macro while held.
  assign gnt     = rst ? arb_gnt : '0;
  assign gnt_any = |gnt;

  always_comb begin
    web_sel   = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    gnt_id    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        web_sel   = web[i*BW +: BW];
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
        gnt_id    = ID_W'(i);
      end
    end
  end

  assign rd_gnt   = gnt_any && (&web_sel);
  assign sram_cs  = gnt_any;
  assign sram_web = gnt_any ? web_sel : '1;
  assign sram_a   = addr_sel;
  assign sram_di  = wdata_sel;

  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (tag_p[i].valid) tag_busy = 1'b1;
    end
  end

  assign sram_oe = rst && (tag_busy || rd_gnt);

  // Stage boundary: grant -> tag pipeline, ptr remembers the last winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= ID_W'(NUM_CH - 1);
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= '0;
    end else begin
      if (gnt_any) ptr <= gnt_id;
      tag_p[0].valid <= rd_gnt;
      tag_p[0].id    <= TAG_ID_MAX_W'(gnt_id);
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Stage boundary: tag exit aligns with valid macro output.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rvalid[i] = tag_p[RD_LAT-1].valid && (tag_p[RD_LAT-1].id == TAG_ID_MAX_W'(i));
    end
  end

  assign rdata = sram_do;

endmodule

// File: tb/tb_sram_arbiter.sv
// Three arbiter instances (RR/lat2, fixed/lat1, RR/lat3) share stimulus; each has its own
// macro model, reference arbiter and read-return scoreboard.
module tb_sram_arbiter;

  localparam int NCH   = 2;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int NINST = 3;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [NCH*BW-1:0] web;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAAAAAAAA;
    return (32'(i) * 32'h9E3779B1) ^ 32'h0F0F0F0F;
  endfunction

  function automatic logic [NCH-1:0] model_gnt(input logic [NCH-1:0] r, input int p, input int mode);
    logic [NCH-1:0] g;
    logic           found;
    int             c;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      c = (mode == 1) ? k : (p + 1 + k) % NCH;
      if (!found && r[c]) begin
        g[c]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NINST; g++) begin : inst
    localparam int LAT  = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int MODE = (g == 1) ? 1 : 0;

    logic [NCH-1:0] gnt, rvalid;
    logic [DW-1:0]  rdata, sdo, sdi;
    logic           cs, oe;
    logic [BW-1:0]  sweb;
    logic [AW-1:0]  sa;
    logic [DW-1:0]  mem    [256];
    logic [DW-1:0]  shadow [256];
    logic [DW-1:0]  dpipe  [LAT];
    exp_t           q[$];
    int             ptr_m, cyc, qn, gid;
    logic [NCH-1:0] eg, erv;
    logic [BW-1:0]  ew;
    logic           busy;
    logic [AW-1:0]  ea;

    sram_arbiter #(
      .NUM_CH   (NCH),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RD_LAT   (LAT),
      .ARB_MODE (MODE)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .web      (web),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .sram_cs  (cs),
      .sram_oe  (oe),
      .sram_web (sweb),
      .sram_a   (sa),
      .sram_di  (sdi),
      .sram_do  (sdo)
    );

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]    = init_word(i);
        shadow[i] = init_word(i);
      end
      ptr_m = NCH - 1;
      cyc   = 0;
      qn    = 0;
    end

    // Macro model: captures on the rising edge, DO valid LAT cycles after capture.
    always @(posedge clk) begin
      if (cs) begin
        if (&sweb) dpipe[0] <= mem[sa];
        else begin
          for (int b = 0; b < BW; b++) begin
            if (!sweb[b]) mem[sa][b*8 +: 8] <= sdi[b*8 +: 8];
          end
        end
      end
      for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign sdo = dpipe[LAT-1];

    always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
        chk($sformatf("i%0d_rst_gnt", g), gnt, 0);
        chk($sformatf("i%0d_rst_cs", g), cs, 0);
        chk($sformatf("i%0d_rst_oe", g), oe, 0);
        chk($sformatf("i%0d_rst_web", g), sweb, 4'hF);
        chk($sformatf("i%0d_rst_rvalid", g), rvalid, 0);
        q.delete();
        ptr_m = NCH - 1;
      end else begin
        erv  = '0;
        busy = (q.size() > 0);
        if (busy && q[0].due == cyc) erv[q[0].ch] = 1'b1;
        chk($sformatf("i%0d_rvalid@%0d", g, cyc), rvalid, erv);
        if (erv != '0) begin
          chk($sformatf("i%0d_rdata@%0d", g, cyc), rdata, q[0].data);
          void'(q.pop_front());
        end
        eg = model_gnt(req, ptr_m, MODE);
        chk($sformatf("i%0d_gnt@%0d", g, cyc), gnt, eg);
        chk($sformatf("i%0d_cs@%0d", g, cyc), cs, |eg);
        gid = 0;
        for (int c = 0; c < NCH; c++) if (eg[c]) gid = c;
        ew = (|eg) ? web[gid*BW +: BW] : '1;
        ea = addr[gid*AW +: AW];
        chk($sformatf("i%0d_web@%0d", g, cyc), sweb, ew);
        chk($sformatf("i%0d_oe@%0d", g, cyc), oe, busy || ((|eg) && (&ew)));
        if (|eg) begin
          chk($sformatf("i%0d_a@%0d", g, cyc), sa, ea);
          ptr_m = gid;
          if (&ew) q.push_back('{gid, shadow[ea], cyc + LAT});
          else begin
            chk($sformatf("i%0d_di@%0d", g, cyc), sdi, wdata[gid*DW +: DW]);
            for (int b = 0; b < BW; b++) begin
              if (!ew[b]) shadow[ea][b*8 +: 8] = wdata[gid*DW + b*8 +: 8];
            end
          end
        end
      end
      qn = q.size();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic r, input logic [BW-1:0] w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c]            = r;
    web[c*BW +: BW]   = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic idle();
    req = '0;
    web = '1;
  endtask

  initial begin
    rst   = 1'b0;
    req   = '1;
    web   = '1;
    addr  = '0;
    wdata = '0;
    repeat (3) next_cycle();
    rst = 1'b1;

    // Both channels requesting continuously.
    for (int i = 0; i < 6; i++) begin
      set_ch(0, 1'b1, '1, 8'h01, '0);
      set_ch(1, 1'b1, '1, 8'h02, '0);
      @(negedge clk);
      chk($sformatf("rr_seq%0d", i), inst[0].gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fixed_seq%0d", i), inst[1].gnt, 2'b01);
      next_cycle();
    end
    idle();
    repeat (4) next_cycle();

    // ch1 reads the DEADBEEF word.
    set_ch(1, 1'b1, '1, 8'h10, '0);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    chk("route_rvalid", inst[0].rvalid, 2'b10);
    chk("route_rdata", inst[0].rdata, 32'hDEADBEEF);
    repeat (4) next_cycle();

    // Low two bytes written, then read back the next cycle.
    set_ch(0, 1'b1, 4'b1100, 8'h20, 32'h11223344);
    next_cycle();
    set_ch(0, 1'b1, '1, 8'h20, '0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("bytewr_rvalid", inst[1].rvalid, 2'b01);
    chk("bytewr_rdata", inst[1].rdata, 32'hAAAA3344);
    repeat (4) next_cycle();

    // Read, read, write on consecutive cycles.
    set_ch(0, 1'b1, '1, 8'h03, '0);
    next_cycle();
    idle();
    set_ch(1, 1'b1, '1, 8'h04, '0);
    next_cycle();
    idle();
    set_ch(0, 1'b1, 4'b0000, 8'h05, 32'h12345678);
    next_cycle();
    idle();
    repeat (5) next_cycle();

    // Reset pulse while a read is in flight.
    set_ch(0, 1'b1, '1, 8'h06, '0);
    next_cycle();
    idle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    set_ch(0, 1'b1, '1, 8'h07, '0);
    set_ch(1, 1'b1, '1, 8'h08, '0);
    @(negedge clk);
    chk("post_rst_gnt_i0", inst[0].gnt, 2'b01);
    chk("post_rst_gnt_i2", inst[2].gnt, 2'b01);
    next_cycle();
    idle();
    repeat (5) next_cycle();

    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < NCH; c++) begin
        set_ch(c, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom),
               8'($urandom_range(0, 15)), $urandom);
      end
      next_cycle();
    end
    idle();
    repeat (6) next_cycle();
    @(negedge clk);
    chk("drain_i0", inst[0].qn, 0);
    chk("drain_i1", inst[1].qn, 0);
    chk("drain_i2", inst[2].qn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised N-channel arbiter that shares one single-port SRAM_wrapper macro (CS/OE/WEB/A/DI/DO) among several requesters, such as the CPU instruction fetch and data ports. This replaces the fixed one-macro-per-port wiring. The block:
- grants one channel per cycle, using round-robin or fixed priority;
- drives the macro directly;
- tags each read in a latency pipeline, so returned data is routed back to the channel that issued it.

## Interface
Parameters:
- NUM_CH, 2, number of requester channels (2..8)
- ADDR_W, 14, word address width to the macro
- DATA_W, 32, data width; multiple of 8
- RD_LAT, 1, cycles from address capture to valid DO (1..4)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_CH  per-channel access request
- web  in  NUM_CH×(DATA_W/8)  per-channel byte write enables, active-low; all ones = read
- addr  in  NUM_CH×ADDR_W  per-channel word address
- wdata  in  NUM_CH×DATA_W  per-channel write data
- gnt  out  NUM_CH  one-hot grant, combinational, same cycle as req
- rvalid  out  NUM_CH  one-hot read-data-valid
- rdata  out  DATA_W  read data, shared; qualified by rvalid
- sram_cs  out  1  macro chip select
- sram_oe  out  1  macro output enable
- sram_web  out  DATA_W/8  macro byte write enables, active-low
- sram_a  out  ADDR_W  macro address
- sram_di  out  DATA_W  macro write data
- sram_do  in  DATA_W  macro read data

## Operation
- Each cycle, at most one gnt bit is high, and only for a channel with req high. No req means gnt = 0 and sram_cs = 0.
- Granted channel's web/addr/wdata are muxed combinationally to sram_web/sram_a/sram_di, with sram_cs = 1. The macro captures them on the next rising edge.
- Non-granted sram_web is held at all ones, so an idle or ungranted cycle never writes.
- Requester holds req/web/addr/wdata stable until it sees gnt. The transfer completes in the gnt cycle.
- Write (any web bit 0): complete at grant; no rvalid.
- Read (web all ones): the tag {valid, channel id} enters an RD_LAT-deep shift register at grant. When the tag exits, rvalid[id] = 1 for exactly one cycle and rdata = sram_do.
- sram_oe = 1 whenever any tag is in flight or a read is granted; otherwise 0.
- Round-robin:
  - ptr holds the last granted id.
  - The search starts at ptr+1 mod NUM_CH.
  - ptr updates only on a grant.
  - Any continuously requesting channel is granted within NUM_CH cycles.
- Fixed priority: the lowest-index requesting channel wins; starvation is permitted.
- Back-to-back reads from the same or different channels are fully pipelined at one per cycle. rvalid order equals grant order.
- Write in cycle t and read of the same address in cycle t+1: the read returns the new data (macro behaviour; no forwarding in this block).

## Timing
- Reset (rst = 0, asynchronous):
  - ptr = NUM_CH−1, so channel 0 wins first;
  - tag pipeline cleared;
  - rvalid = 0;
  - gnt, sram_cs and sram_oe forced 0;
  - sram_web forced all ones.
- Reset mid-operation: in-flight reads are dropped and no rvalid is issued for them. After release, the first cycle arbitrates normally.
- Read latency: grant in cycle t gives rvalid in cycle t+RD_LAT.
- Grant latency: 0 cycles when uncontended.
- Tag id width is $clog2(NUM_CH), minimum 1.
- Release of rst is synchronised by the integrator, not by this block.

## Structure
- sram_arb_pkg holds:
  - arb_mode_e {ARB_RR, ARB_FIXED};
  - function id_w(n) returning max(1, $clog2(n));
  - struct rd_tag_t {valid, id}, parameterised through localparams in the block.
- One sub-module, rr_arbiter: inputs req, ptr, mode; output one-hot gnt. Purely combinational, instantiated once.
- Tag shift register, ptr register and macro muxes live in sram_arbiter.

## Test plan
- Reset: with rst held low and req = all ones, gnt = 0, sram_cs = 0, sram_web = 4'hF, rvalid = 0. After release, first grant goes to channel 0.
- RR fairness: NUM_CH = 2, both req high continuously for 6 cycles, then gnt = 01,10,01,10,01,10. ARB_MODE = 1 gives 01 every cycle.
- Read routing, RD_LAT = 2:
  - ch1 reads addr 0x10, which holds 0xDEADBEEF, at cycle 5;
  - rvalid = 10 at cycle 7 with rdata = 0xDEADBEEF;
  - no other rvalid.
- Byte write then read:
  - ch0 writes 0x11223344 to addr 0x20 with web = 4'b1100 over initial 0xAAAAAAAA, then reads next cycle;
  - rdata = 0xAAAA3344.
- Pipelined mix, RD_LAT = 1: ch0 read A, ch1 read B, ch0 write C in consecutive cycles gives rvalid = 01 then 10 on successive cycles, then none for the write.
- Mid-flight reset: RD_LAT = 3, read granted; pulse rst low one cycle later; no rvalid appears, and ptr is back to NUM_CH−1.
